avmm_ccip_burst_adapter: RTL and testbench
==========================================

Name: avmm_ccip_burst_adapter

Overview:
- Sits directly upstream of avmm_ccip_host, between the DMA/user Avalon-MM master and the host bridge.
- Accepts arbitrary-length Avalon bursts of 1..2^(BURST_WIDTH-1) cache lines.
- Splits each burst into CCI-P-legal sub-bursts: 1, 2 or 4 lines, each naturally aligned and never crossing a 4-line boundary.
- Passes write data and read responses through unchanged, in order. In-order read responses are guaranteed by MPF.

Parameters:
ADDR_WIDTH, 49, byte address width; bit 48 is the write-fence flag, bits 47:6 are the line address.
DATA_WIDTH, 512, data width (one cache line per beat).
BURST_WIDTH, 7, slave burstcount width; maximum burst is 64 lines.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
s_address  in  ADDR_WIDTH  slave byte address; bits 5:0 are zero
s_burstcount  in  BURST_WIDTH  slave burst length in lines
s_read  in  1  slave read request
s_write  in  1  slave write beat
s_writedata  in  DATA_WIDTH  slave write data
s_byteenable  in  DATA_WIDTH/8  slave byte enables
s_waitrequest  out  1  slave backpressure
s_readdata  out  DATA_WIDTH  read data
s_readdatavalid  out  1  read data valid
m_address  out  ADDR_WIDTH  to host bridge avmm_address
m_burstcount  out  3  to host bridge; only values 1, 2 or 4
m_read  out  1  to host bridge
m_write  out  1  to host bridge
m_writedata  out  DATA_WIDTH  to host bridge
m_byteenable  out  DATA_WIDTH/8  to host bridge
m_waitrequest  in  1  from host bridge
m_readdata  in  DATA_WIDTH  from host bridge
m_readdatavalid  in  1  from host bridge

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values:
  - state=IDLE, all counters 0.
  - m_read=0, m_write=0, s_readdatavalid follows m_readdatavalid (0 under bridge reset).
  - s_waitrequest=1 while reset is asserted.
- Chunk rule, given line offset a = line[1:0] and remaining lines R:
  - a==0 and R>=4 -> 4;
  - else a[0]==0 and R>=2 -> 2;
  - else 1.
- Read response path: s_readdata=m_readdata and s_readdatavalid=m_readdatavalid, combinational, zero latency.
- FSM states: IDLE, RD_ISSUE, WR_BURST.
- IDLE, write:
  - s_waitrequest=m_waitrequest.
  - m_write=s_write; m_address=s_address; m_burstcount=chunk(s_address line, s_burstcount).
  - Beat is accepted when s_write & ~m_waitrequest.
  - If s_burstcount==1, stay in IDLE.
  - Otherwise go to WR_BURST with rem=N-1, chunk_left=chunk-1, next_line=line+1.
- IDLE, read:
  - s_waitrequest=0; command captured into registers (line, N, bit48).
  - Next state RD_ISSUE. Adds one cycle of command latency.
- RD_ISSUE:
  - s_waitrequest=1; m_read=1.
  - m_address = {bit48 on first sub-burst only, cur_line, 6'b0}; m_burstcount=chunk(cur_line, rem).
  - On ~m_waitrequest: cur_line += chunk, rem -= chunk. When rem reaches 0, return to IDLE.
- WR_BURST:
  - s_waitrequest=m_waitrequest; m_write=s_write; data and byteenable pass through.
  - m_address is held at the current sub-burst start address for all beats of that sub-burst.
  - On each accepted beat:
    - If chunk_left==0, the beat starts a new sub-burst: sub_addr=next_line, m_burstcount=chunk(next_line, rem), chunk_left=that chunk-1.
    - Otherwise chunk_left decrements.
    - In both cases rem decrements and next_line increments.
  - Return to IDLE when the last beat (rem==1) is accepted.
  - Idle cycles with s_write=0 between beats are legal; nothing is forwarded during them.
- Fence flag (address bit 48): forwarded only on the first sub-burst of a write or read; cleared on all later sub-bursts. This gives exactly one fence per original write burst.
- m_burstcount and m_address remain stable while m_waitrequest=1 (Avalon hold rule).
- Illegal input (s_read & s_write together, or s_burstcount==0):
  - Write takes priority; burstcount 0 is treated as 1.
  - Simulation assertion fires.
- Line address wraps modulo 2^42 without carry into bit 48.
- Reset mid-burst aborts the transaction; residual beats are not generated.

Decomposition:
- ccip_avmm_pkg gains:
  - enum t_burst_adapt_state;
  - function ccip_burst_chunk(line[1:0], rem) returning 3 bits;
  - localparam CCIP_AVMM_MAX_CL_BURST = 4.
- No sub-module. The chunk function is shared by the read and write paths.

Test Plan:
- Read, line 0x1, burst 7 -> m reads (0x1,1), (0x2,2), (0x4,4); 7 readdatavalid beats returned in order.
- Write, line 0x0, burst 8, no backpressure -> sub-bursts (0x0,4) and (0x4,4); m_address held per sub-burst; 8 data beats match.
- Write, addr bit48=1, line 0x2, burst 3 -> (0x2,2) with bit48=1, then (0x3 boundary: 0x4,1) with bit48=0.
- Write, burst 4, m_waitrequest high for 3 cycles on beat 2 and s_write gaps on beat 3 -> no beats lost or duplicated; m signals held stable during the stall.
- Reset asserted in RD_ISSUE after the first sub-burst -> m_read=0 immediately; state IDLE; next read burst 2 at line 0x0 -> single (0x0,2).
- Read, line 0x3, burst 1 -> single (0x3,1); s_waitrequest back to 0 within 2 cycles.

Source files
------------

// File: rtl/ccip_avmm_pkg.sv
// Shared types and helpers for the Avalon-MM to CCI-P host path.
// The chunk function picks the largest legal CCI-P sub-burst at a given line offset.
package ccip_avmm_pkg;

  localparam int CCIP_AVMM_MAX_CL_BURST = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    WR_BURST
  } t_burst_adapt_state;

  // Sub-bursts must be naturally aligned and never straddle a 4-line boundary.
  function automatic logic [2:0] ccip_burst_chunk(input logic [1:0] line_lo,
                                                  input logic [15:0] rem);
    logic [2:0] chunk;
    if (line_lo == 2'b00 && rem >= 16'(CCIP_AVMM_MAX_CL_BURST)) chunk = 3'd4;
    else if (!line_lo[0] && rem >= 16'd2) chunk = 3'd2;
    else chunk = 3'd1;
    return chunk;
  endfunction

endpackage

// File: rtl/avmm_ccip_burst_adapter.sv
// Splits arbitrary-length Avalon-MM bursts into aligned 1/2/4-line CCI-P sub-bursts.
// Write data and read responses pass straight through in order.
module avmm_ccip_burst_adapter
  import ccip_avmm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 49,
  parameter int DATA_WIDTH  = 512,
  parameter int BURST_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_address,
  input  logic [BURST_WIDTH-1:0]  s_burstcount,
  input  logic                    s_read,
  input  logic                    s_write,
  input  logic [DATA_WIDTH-1:0]   s_writedata,
  input  logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic                    s_waitrequest,
  output logic [DATA_WIDTH-1:0]   s_readdata,
  output logic                    s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic [2:0]              m_burstcount,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  input  logic                    m_waitrequest,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_readdatavalid
);

  localparam int LW = ADDR_WIDTH - 7;

  t_burst_adapt_state state;

  logic [LW-1:0]          rd_line;
  logic [BURST_WIDTH-1:0] rd_rem;
  logic                   rd_fence;
  logic [BURST_WIDTH-1:0] wr_rem;
  logic [2:0]             chunk_left;
  logic [LW-1:0]          next_line;
  logic [ADDR_WIDTH-1:0]  sub_addr;
  logic [2:0]             sub_cnt;

  logic [BURST_WIDTH-1:0] s_len;
  logic [LW-1:0]          s_line;
  logic [2:0]             s_chunk;
  logic [2:0]             rd_chunk;
  logic [2:0]             nx_chunk;
  logic                   wr_beat;

  // A zero burstcount is treated as a single line.
  assign s_len    = (s_burstcount == '0) ? BURST_WIDTH'(1) : s_burstcount;
  assign s_line   = s_address[ADDR_WIDTH-2:6];
  assign s_chunk  = ccip_burst_chunk(s_line[1:0], 16'(s_len));
  assign rd_chunk = ccip_burst_chunk(rd_line[1:0], 16'(rd_rem));
  assign nx_chunk = ccip_burst_chunk(next_line[1:0], 16'(wr_rem));
  assign wr_beat  = s_write & ~m_waitrequest;

  assign s_readdata      = m_readdata;
  assign s_readdatavalid = m_readdatavalid;
  assign m_writedata     = s_writedata;
  assign m_byteenable    = s_byteenable;

  // Command side; everything is driven from stable registers or held slave inputs,
  // so address and burstcount cannot move while the bridge stalls.
  always_comb begin
    s_waitrequest = 1'b1;
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_address     = s_address;
    m_burstcount  = s_chunk;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (s_write) begin
            s_waitrequest = m_waitrequest;
            m_write       = 1'b1;
          end else begin
            s_waitrequest = 1'b0;
          end
        end
        RD_ISSUE: begin
          m_read       = 1'b1;
          m_address    = {rd_fence, rd_line, 6'b0};
          m_burstcount = rd_chunk;
        end
        WR_BURST: begin
          s_waitrequest = m_waitrequest;
          m_write       = s_write;
          if (chunk_left == 3'd0) begin
            m_address    = {1'b0, next_line, 6'b0};
            m_burstcount = nx_chunk;
          end else begin
            m_address    = sub_addr;
            m_burstcount = sub_cnt;
          end
        end
        default: s_waitrequest = 1'b1;
      endcase
    end
  end

  // Burst bookkeeping; the fence bit only ever survives into the first sub-burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_line    <= '0;
      rd_rem     <= '0;
      rd_fence   <= 1'b0;
      wr_rem     <= '0;
      chunk_left <= '0;
      next_line  <= '0;
      sub_addr   <= '0;
      sub_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_write) begin
            if (!m_waitrequest && s_len != BURST_WIDTH'(1)) begin
              state      <= WR_BURST;
              wr_rem     <= s_len - BURST_WIDTH'(1);
              chunk_left <= s_chunk - 3'd1;
              next_line  <= s_line + LW'(1);
              sub_addr   <= s_address;
              sub_cnt    <= s_chunk;
            end
          end else if (s_read) begin
            state    <= RD_ISSUE;
            rd_line  <= s_line;
            rd_rem   <= s_len;
            rd_fence <= s_address[ADDR_WIDTH-1];
          end
        end
        RD_ISSUE: begin
          if (!m_waitrequest) begin
            rd_line  <= rd_line + LW'(rd_chunk);
            rd_rem   <= rd_rem - BURST_WIDTH'(rd_chunk);
            rd_fence <= 1'b0;
            if (rd_rem == BURST_WIDTH'(rd_chunk)) state <= IDLE;
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            if (chunk_left == 3'd0) begin
              sub_addr   <= {1'b0, next_line, 6'b0};
              sub_cnt    <= nx_chunk;
              chunk_left <= nx_chunk - 3'd1;
            end else begin
              chunk_left <= chunk_left - 3'd1;
            end
            wr_rem    <= wr_rem - BURST_WIDTH'(1);
            next_line <= next_line + LW'(1);
            if (wr_rem == BURST_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  illegal_cmd: assert property (@(posedge clk) disable iff (reset)
    (state == IDLE && (s_read || s_write)) |-> (!(s_read && s_write) && s_burstcount != '0));

endmodule

// File: tb/tb_avmm_ccip_burst_adapter.sv
// Randomized bench for avmm_ccip_burst_adapter: a host-bridge responder on the m side
// and a reference splitter that derives the expected sub-burst plan from plain arithmetic.
module tb_avmm_ccip_burst_adapter;

  localparam int AW = 49;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int LW = 42;

  logic              clk = 1'b0;
  logic              reset;
  logic [AW-1:0]     s_address;
  logic [BW-1:0]     s_burstcount;
  logic              s_read;
  logic              s_write;
  logic [DW-1:0]     s_writedata;
  logic [DW/8-1:0]   s_byteenable;
  logic              s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic              s_readdatavalid;
  logic [AW-1:0]     m_address;
  logic [2:0]        m_burstcount;
  logic              m_read;
  logic              m_write;
  logic [DW-1:0]     m_writedata;
  logic [DW/8-1:0]   m_byteenable;
  logic              m_waitrequest = 1'b0;
  logic [DW-1:0]     m_readdata = '0;
  logic              m_readdatavalid = 1'b0;

  avmm_ccip_burst_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit force_wait = 1'b0;
  bit rand_wait  = 1'b0;
  bit resp_en    = 1'b1;
  int last_ready_cycles;

  logic [AW-1:0]   cmd_addr[$];
  logic [2:0]      cmd_bc[$];
  logic [AW-1:0]   wr_addr[$];
  logic [2:0]      wr_bc[$];
  logic [DW-1:0]   wr_data[$];
  logic [DW/8-1:0] wr_be[$];
  logic [DW-1:0]   rd_pending[$];
  logic [DW-1:0]   rd_got[$];
  logic [DW-1:0]   sent_data[$];
  logic [DW/8-1:0] sent_be[$];
  logic [LW-1:0]   exp_line[$];
  int              exp_size[$];

  bit              stall_prev = 1'b0;
  logic [AW-1:0]   prev_addr;
  logic [2:0]      prev_bc;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] data_for_line(input logic [LW-1:0] line);
    return {16{line[31:0] ^ 32'hA5A5_0000}};
  endfunction

  // Reference split: at each step take the largest of 4/2/1 that fits and is aligned.
  task automatic build_plan(input logic [LW-1:0] line, input int n);
    logic [LW-1:0] cur;
    int left;
    int sz;
    cur  = line;
    left = n;
    exp_line.delete();
    exp_size.delete();
    while (left > 0) begin
      sz = 4;
      while (sz > left || (cur % LW'(sz)) != 0) sz = sz / 2;
      exp_line.push_back(cur);
      exp_size.push_back(sz);
      cur  = cur + LW'(sz);
      left = left - sz;
    end
  endtask

  // Bridge model: stall generator plus in-order read responder.
  always @(posedge clk) begin
    #2;
    m_waitrequest = force_wait | (rand_wait && ($urandom_range(0, 2) == 0));
    if (reset) begin
      rd_pending.delete();
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
    end else if (resp_en && rd_pending.size() > 0 && $urandom_range(0, 3) != 0) begin
      m_readdata      = rd_pending.pop_front();
      m_readdatavalid = 1'b1;
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata      = '0;
    end
  end

  // Monitor: records accepted commands/beats and enforces the Avalon hold rule.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (m_read || m_write)) begin
        checkOutput("hold_addr", DW'(m_address), DW'(prev_addr));
        checkOutput("hold_bc", DW'(m_burstcount), DW'(prev_bc));
      end
      if (m_read && !m_waitrequest) begin
        cmd_addr.push_back(m_address);
        cmd_bc.push_back(m_burstcount);
        for (int k = 0; k < int'(m_burstcount); k++)
          rd_pending.push_back(data_for_line(m_address[AW-2:6] + LW'(k)));
      end
      if (m_write && !m_waitrequest) begin
        wr_addr.push_back(m_address);
        wr_bc.push_back(m_burstcount);
        wr_data.push_back(m_writedata);
        wr_be.push_back(m_byteenable);
      end
      stall_prev = (m_read || m_write) && m_waitrequest;
      prev_addr  = m_address;
      prev_bc    = m_burstcount;
      if (s_readdatavalid) rd_got.push_back(s_readdata);
    end
  end

  task automatic wait_accept(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (s_waitrequest && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (s_waitrequest) checkOutput(tag, DW'(s_waitrequest), DW'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit is_wr, input bit fence, input logic [LW-1:0] line,
                               input int n, input bit gaps, input int stall_beat,
                               input int gap_beat);
    int cyc;
    int ci;
    int left_in_chunk;
    int ng;
    logic [AW-1:0] exp_a;
    build_plan(line, n);
    cmd_addr.delete(); cmd_bc.delete();
    wr_addr.delete(); wr_bc.delete(); wr_data.delete(); wr_be.delete();
    sent_data.delete(); sent_be.delete(); rd_got.delete();
    if (is_wr) begin
      for (int i = 0; i < n; i++) begin
        ng = (i == gap_beat) ? 2 : (gaps ? $urandom_range(0, 2) : 0);
        repeat (ng) begin
          s_write = 1'b0;
          @(posedge clk);
          #1;
        end
        s_write      = 1'b1;
        s_address    = {fence, line, 6'b0};
        s_burstcount = BW'(n);
        for (int w = 0; w < 16; w++) s_writedata[w*32 +: 32] = $urandom;
        s_byteenable = {$urandom, $urandom};
        sent_data.push_back(s_writedata);
        sent_be.push_back(s_byteenable);
        if (i == stall_beat) begin
          force_wait = 1'b1;
          repeat (3) begin
            @(posedge clk);
            #1;
          end
          force_wait = 1'b0;
        end
        wait_accept("wr_accept_timeout");
      end
      s_write = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("wr_beat_count", DW'(wr_data.size()), DW'(n));
      ci = 0;
      left_in_chunk = exp_size[0];
      for (int i = 0; i < n && i < wr_data.size(); i++) begin
        exp_a = {fence && (ci == 0), exp_line[ci], 6'b0};
        checkOutput("wr_addr", DW'(wr_addr[i]), DW'(exp_a));
        checkOutput("wr_bc", DW'(wr_bc[i]), DW'(exp_size[ci]));
        checkOutput("wr_data", wr_data[i], sent_data[i]);
        checkOutput("wr_be", DW'(wr_be[i]), DW'(sent_be[i]));
        left_in_chunk--;
        if (left_in_chunk == 0 && ci + 1 < exp_size.size()) begin
          ci++;
          left_in_chunk = exp_size[ci];
        end
      end
    end else begin
      s_read       = 1'b1;
      s_address    = {fence, line, 6'b0};
      s_burstcount = BW'(n);
      wait_accept("rd_accept_timeout");
      s_read = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (s_waitrequest && cyc < 2000);
      last_ready_cycles = cyc;
      while (rd_got.size() < n && cyc < 4000) begin
        @(negedge clk);
        cyc++;
      end
      if (rd_got.size() < n) checkOutput("rd_beats_timeout", DW'(rd_got.size()), DW'(n));
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rd_cmd_count", DW'(cmd_addr.size()), DW'(exp_line.size()));
      for (int c = 0; c < exp_line.size() && c < cmd_addr.size(); c++) begin
        exp_a = {fence && (c == 0), exp_line[c], 6'b0};
        checkOutput("rd_addr", DW'(cmd_addr[c]), DW'(exp_a));
        checkOutput("rd_bc", DW'(cmd_bc[c]), DW'(exp_size[c]));
      end
      checkOutput("rd_beat_count", DW'(rd_got.size()), DW'(n));
      for (int i = 0; i < n && i < rd_got.size(); i++)
        checkOutput("rd_data", rd_got[i], data_for_line(line + LW'(i)));
    end
  endtask

  initial begin
    logic [63:0]   rnd;
    logic [LW-1:0] rline;
    reset        = 1'b1;
    s_read       = 1'b0;
    s_write      = 1'b1;
    s_address    = '0;
    s_burstcount = BW'(1);
    s_writedata  = '0;
    s_byteenable = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_s_waitrequest", DW'(s_waitrequest), DW'(1));
    checkOutput("reset_m_write", DW'(m_write), DW'(0));
    checkOutput("reset_m_read", DW'(m_read), DW'(0));
    checkOutput("reset_s_readdatavalid", DW'(s_readdatavalid), DW'(0));
    @(posedge clk);
    #1;
    s_write = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed bursts");
    applyStimulus(1'b0, 1'b0, LW'(1), 7, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b0, LW'(0), 8, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b1, LW'(2), 3, 1'b0, -1, -1);
    applyStimulus(1'b1, 1'b0, LW'(16), 4, 1'b0, 1, 2);

    $display("[TB] reset during read issue");
    resp_en      = 1'b0;
    s_read       = 1'b1;
    s_address    = '0;
    s_burstcount = BW'(8);
    wait_accept("rst_rd_accept_timeout");
    s_read = 1'b0;
    @(negedge clk);
    checkOutput("rst_first_m_read", DW'(m_read), DW'(1));
    @(posedge clk);
    #1;
    force_wait = 1'b1;
    @(negedge clk);
    checkOutput("rst_second_m_read", DW'(m_read), DW'(1));
    checkOutput("rst_second_addr", DW'(m_address), DW'({1'b0, LW'(4), 6'b0}));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rst_m_read_drop", DW'(m_read), DW'(0));
    checkOutput("rst_s_waitrequest", DW'(s_waitrequest), DW'(1));
    force_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, LW'(0), 2, 1'b0, -1, -1);

    applyStimulus(1'b0, 1'b0, LW'(3), 1, 1'b0, -1, -1);
    checkOutput("rd1_ready_within_2", DW'(last_ready_cycles <= 2), DW'(1));

    $display("[TB] randomized bursts with backpressure");
    rand_wait = 1'b1;
    for (int it = 0; it < 24; it++) begin
      rnd   = {$urandom, $urandom};
      rline = rnd[LW-1:0];
      if ($urandom_range(0, 3) == 0) rline = '1 - LW'($urandom_range(0, 5));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rline,
                    $urandom_range(1, 64), 1'($urandom_range(0, 1)), -1, -1);
    end
    rand_wait = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
